// File: rtl/seq_ser_pkg.sv
// seq_ser_pkg: shared FSM state type and counter-width helper for the serializer.
package seq_ser_pkg;
  typedef enum logic {IDLE, SHIFT} ser_state_t;
  function automatic int cnt_w(input int w);
    return (w > 2) ? $clog2(w) : 1;
  endfunction
endpackage

// File: rtl/seq_ser_hold.sv
// seq_ser_hold: one-entry holding register that buffers the next word while one shifts.
module seq_ser_hold #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr,
  input  logic             rd,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             full
);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full <= 1'b0;
      q    <= '0;
    end else begin
      full <= rd ? 1'b0 : (wr ? 1'b1 : full);
      if (wr) q <= d;
    end
  end
endmodule

// File: rtl/seq_serializer.sv
// seq_serializer: valid/ready word input, one registered bit per clk on sout, gapless via hold register.
module seq_serializer
  import seq_ser_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0,
  localparam int CW       = cnt_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_active,
  output logic             word_start,
  output logic [CW-1:0]    bit_idx
);
  ser_state_t state, nstate;
  logic [WIDTH-1:0] sreg, hq, word, src;
  logic [CW-1:0] cnt;
  logic hold_full, xfer, last, ld, adv, hwr, hrd;
  assign din_ready = !hold_full;
  assign xfer      = din_valid && din_ready;
  assign last      = cnt == CW'(WIDTH - 1);
  assign word      = hold_full ? hq : din;
  assign src       = ld ? word : sreg;
  assign bit_idx   = cnt;
  seq_ser_hold #(.WIDTH(WIDTH)) u_hold (
    .clk (clk),
    .rst (rst),
    .wr  (hwr),
    .rd  (hrd),
    .d   (din),
    .q   (hq),
    .full(hold_full)
  );
  always_comb begin
    nstate = state;
    ld     = 1'b0;
    adv    = 1'b0;
    hwr    = 1'b0;
    hrd    = 1'b0;
    if (state == IDLE) begin
      ld     = xfer;
      nstate = xfer ? SHIFT : IDLE;
    end else if (!last) begin
      adv = 1'b1;
      hwr = xfer;
    end else begin
      hrd    = hold_full;
      ld     = hold_full || xfer;
      nstate = ld ? SHIFT : IDLE;
    end
  end
  // sreg always holds the bits still to be sent, already aligned for the next pick
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      sreg        <= '0;
      cnt         <= '0;
      sout        <= IDLE_BIT;
      sout_active <= 1'b0;
      word_start  <= 1'b0;
    end else begin
      state       <= nstate;
      sout_active <= nstate == SHIFT;
      word_start  <= ld;
      if (ld || adv) begin
        sout <= MSB_FIRST ? src[WIDTH-1] : src[0];
        sreg <= MSB_FIRST ? src << 1 : src >> 1;
        cnt  <= ld ? '0 : cnt + 1'b1;
      end else begin
        sout <= IDLE_BIT;
      end
    end
  end
endmodule
